// File: rtl/mov_pkg.sv
// ---------------------------------------------------------------------------
// mov_pkg
// Shared definitions for the pipelined move unit: funct encodings, the
// decoded operation enum, the decode payload struct and the decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mov_pkg;

  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FN_MOVE = 6'b110000;
  localparam logic [FUNCT_W-1:0] FN_CMOV = 6'b110001;
  localparam logic [FUNCT_W-1:0] FN_UMAX = 6'b110010;
  localparam logic [FUNCT_W-1:0] FN_SMIN = 6'b110011;
  localparam logic [FUNCT_W-1:0] FN_SMAX = 6'b110100;

  typedef enum logic [1:0] {
    OP_MOVE = 2'd0,
    OP_MIN  = 2'd1,
    OP_MAX  = 2'd2,
    OP_ILL  = 2'd3
  } op_e;

  // Decoded operation: selection form plus signedness of the compare
  typedef struct packed {
    op_e  op;
    logic sgn;
  } dec_t;

  // Map a funct code onto a selection form; unknown codes become OP_ILL
  function automatic dec_t decode_funct(input logic [FUNCT_W-1:0] f);
    dec_t d;
    d.op  = OP_ILL;
    d.sgn = 1'b0;
    case (f)
      FN_MOVE: d.op = OP_MOVE;
      FN_CMOV: d.op = OP_MIN;
      FN_UMAX: d.op = OP_MAX;
      FN_SMIN: begin d.op = OP_MIN; d.sgn = 1'b1; end
      FN_SMAX: begin d.op = OP_MAX; d.sgn = 1'b1; end
      default: d.op = OP_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mov_cmp_sel.sv
// ---------------------------------------------------------------------------
// mov_cmp_sel
// Combinational comparator and result selector for the move unit.
// The compare half works on the incoming operands (its result is registered
// in S1); the select half works on the S1 registers and feeds S2.
//   i_a, i_b   : operands to compare (rs2, rs3)
//   i_sgn      : 1 = two's-complement compare, 0 = unsigned
//   o_lt_c     : i_a < i_b (strict)
//   i_op       : decoded selection form from S1
//   i_lt       : registered compare result from S1
//   i_rs2/rs3  : registered operands from S1
//   o_res_c    : selected result
//   o_ill_c    : operation was illegal
// ---------------------------------------------------------------------------
module mov_cmp_sel
  import mov_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sgn,
  output logic             o_lt_c,
  input  op_e              i_op,
  input  logic             i_lt,
  input  logic [WIDTH-1:0] i_rs2,
  input  logic [WIDTH-1:0] i_rs3,
  output logic [WIDTH-1:0] o_res_c,
  output logic             o_ill_c
);

  // Strict less-than; bit WIDTH-1 is the sign bit in signed mode
  always_comb begin
    o_lt_c = 1'b0;
    if (i_sgn) o_lt_c = $signed(i_a) < $signed(i_b);
    else       o_lt_c = i_a < i_b;
  end

  // On a tie lt=0, so min returns rs3 and max returns rs2 (equal values)
  always_comb begin
    o_res_c = '0;
    o_ill_c = 1'b0;
    case (i_op)
      OP_MOVE: o_res_c = i_rs2;
      OP_MIN:  o_res_c = i_lt ? i_rs2 : i_rs3;
      OP_MAX:  o_res_c = i_lt ? i_rs3 : i_rs2;
      OP_ILL:  o_ill_c = 1'b1;
      default: o_ill_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mov_unit_pipe.sv
// ---------------------------------------------------------------------------
// mov_unit_pipe
// Two-stage pipelined move unit (MOVE, unsigned/signed min and max) with a
// valid/ready handshake on both sides and a writeback tag.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake (in_ready never looks at in_valid)
//   rs1                 : carried for future modes, currently ignored
//   rs2, rs3            : operands
//   funct               : operation select
//   rd_in               : destination tag
//   out_valid/out_ready : result handshake
//   out, rd_out         : registered result and its tag
//   illegal             : result came from an unsupported funct (out = 0)
// ---------------------------------------------------------------------------
module mov_unit_pipe
  import mov_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned TAG_W        = 5,
  parameter int unsigned CLR_ON_STALL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   rs1,
  input  logic [WIDTH-1:0]   rs2,
  input  logic [WIDTH-1:0]   rs3,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [TAG_W-1:0]   rd_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic [TAG_W-1:0]   rd_out,
  output logic               illegal
);

  // S1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_rs2;
  logic [WIDTH-1:0] r_s1_rs3;
  logic [TAG_W-1:0] r_s1_tag;
  op_e              r_s1_op;
  logic             r_s1_lt;

  // S2 registers
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_out;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_ill;

  logic             w_s2_take;
  logic             w_s1_take;
  logic             w_in_xfer;
  logic             w_s1_move;
  dec_t             w_dec;
  logic             w_lt;
  logic [WIDTH-1:0] w_res;
  logic             w_ill;
  logic             w_unused;

  // rs1 and the stall-clear option are reserved; outputs always hold on stall
  assign w_unused = ^{rs1, 1'(CLR_ON_STALL != 0)};

  // Handshake: a stage can load when empty or when the stage after it drains
  assign w_s2_take = !r_s2_valid || out_ready;
  assign w_s1_take = !r_s1_valid || w_s2_take;
  assign in_ready  = w_s1_take;
  assign w_in_xfer = in_valid && w_s1_take;
  assign w_s1_move = r_s1_valid && w_s2_take;

  assign w_dec = decode_funct(funct);

  mov_cmp_sel #(
    .WIDTH (WIDTH)
  ) u_cmp_sel (
    .i_a     (rs2),
    .i_b     (rs3),
    .i_sgn   (w_dec.sgn),
    .o_lt_c  (w_lt),
    .i_op    (r_s1_op),
    .i_lt    (r_s1_lt),
    .i_rs2   (r_s1_rs2),
    .i_rs3   (r_s1_rs3),
    .o_res_c (w_res),
    .o_ill_c (w_ill)
  );

  // Stage 1: operands, tag, decoded op and registered compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_rs2   <= '0;
      r_s1_rs3   <= '0;
      r_s1_tag   <= '0;
      r_s1_op    <= OP_MOVE;
      r_s1_lt    <= 1'b0;
    end else begin
      if (w_s1_take) r_s1_valid <= in_valid;
      if (w_in_xfer) begin
        r_s1_rs2 <= rs2;
        r_s1_rs3 <= rs3;
        r_s1_tag <= rd_in;
        r_s1_op  <= w_dec.op;
        r_s1_lt  <= w_lt;
      end
    end
  end

  // Stage 2: selected result; data only changes when a new result arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_out   <= '0;
      r_s2_tag   <= '0;
      r_s2_ill   <= 1'b0;
    end else begin
      if (w_s2_take) r_s2_valid <= r_s1_valid;
      if (w_s1_move) begin
        r_s2_out <= w_res;
        r_s2_tag <= r_s1_tag;
        r_s2_ill <= w_ill;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out       = r_s2_out;
  assign rd_out    = r_s2_tag;
  assign illegal   = r_s2_ill;

endmodule

// File: tb/tb_mov_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_mov_unit_pipe
// Directed bench for mov_unit_pipe: reset, operation table, throughput,
// backpressure, illegal codes and asynchronous reset mid-flight.
// ---------------------------------------------------------------------------
module tb_mov_unit_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;

  localparam logic [5:0] F_MOVE = 6'b110000;
  localparam logic [5:0] F_CMOV = 6'b110001;
  localparam logic [5:0] F_UMAX = 6'b110010;
  localparam logic [5:0] F_SMIN = 6'b110011;
  localparam logic [5:0] F_SMAX = 6'b110100;
  localparam logic [5:0] F_BAD  = 6'b111111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  rs1 = '0;
  logic [W-1:0]  rs2 = '0;
  logic [W-1:0]  rs3 = '0;
  logic [5:0]    funct = '0;
  logic [TW-1:0] rd_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out;
  logic [TW-1:0] rd_out;
  logic          illegal;

  mov_unit_pipe #(
    .WIDTH        (W),
    .TAG_W        (TW),
    .CLR_ON_STALL (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs3       (rs3),
    .funct     (funct),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .rd_out    (rd_out),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: a transfer is recorded in the cycle it is offered
  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    logic          i;
    int            c;
  } rec_t;
  rec_t got_q[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rec_t r;
      r.d = out; r.t = rd_out; r.i = illegal; r.c = cyc;
      got_q.push_back(r);
    end
  end

  // Present one operand set and hold it until accepted; returns at posedge+1
  task automatic send(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t, output int t_acc, output int stalls);
    funct = f; rs1 = ~a; rs2 = a; rs3 = b; rd_in = t; in_valid = 1'b1;
    t_acc = -1; stalls = 0;
    for (int g = 0; g < 50 && t_acc < 0; g++) begin
      @(negedge clk);
      if (in_ready) t_acc = cyc;
      else          stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (t_acc < 0) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_res(output rec_t r, output bit ok);
    ok = 1'b0;
    r.d = '0; r.t = '0; r.i = 1'b0; r.c = 0;
    for (int g = 0; g < 20 && got_q.size() == 0; g++) begin
      @(posedge clk); #1;
    end
    if (got_q.size() != 0) begin
      r = got_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // One op end to end: result, tag, illegal flag and 2-cycle latency
  task automatic run_one(input string name, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] t,
                         input logic [W-1:0] exp_d, input logic exp_i);
    int   ta, st;
    rec_t r;
    bit   ok;
    got_q.delete();
    send(f, a, b, t, ta, st);
    wait_res(r, ok);
    if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
    else begin
      check({name, "_out"}, 64'(r.d), 64'(exp_d));
      check({name, "_tag"}, 64'(r.t), 64'(t));
      check({name, "_ill"}, 64'(r.i), 64'(exp_i));
      check({name, "_lat"}, 64'(r.c - ta), 64'd2);
    end
  endtask

  logic [W-1:0] all1;

  initial begin
    int   ta, st, st_tot;
    all1 = '1;

    // 1. reset, then a single MOVE with exact latency
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_outs", 64'({out_valid, illegal, rd_out, out}), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    funct = F_MOVE; rs2 = 32'h0000_00AB; rs3 = '0; rd_in = 5'd7; in_valid = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("move_v_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("move_v", 64'(out_valid), 64'd1);
    check("move_out", 64'(out), 64'h0AB);
    check("move_tag", 64'(rd_out), 64'd7);
    check("move_ill", 64'(illegal), 64'd0);
    @(posedge clk); #1;

    // 2. signed vs unsigned compare, then ties
    run_one("cmov",  F_CMOV, all1, W'(1), 5'd1, W'(1), 1'b0);
    run_one("umax",  F_UMAX, all1, W'(1), 5'd2, all1,  1'b0);
    run_one("smin",  F_SMIN, all1, W'(1), 5'd3, all1,  1'b0);
    run_one("smax",  F_SMAX, all1, W'(1), 5'd4, W'(1), 1'b0);
    run_one("tie_cmov", F_CMOV, W'(5), W'(5), 5'd5, W'(5), 1'b0);
    run_one("tie_umax", F_UMAX, W'(5), W'(5), 5'd6, W'(5), 1'b0);
    run_one("tie_smin", F_SMIN, W'(5), W'(5), 5'd7, W'(5), 1'b0);
    run_one("tie_smax", F_SMAX, W'(5), W'(5), 5'd8, W'(5), 1'b0);

    // 3. eight back-to-back ops
    got_q.delete();
    st_tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(F_MOVE, W'(100 + i), W'(0), TW'(i), ta, st);
      st_tot += st;
    end
    repeat (4) begin @(posedge clk); #1; end
    check("b2b_stalls", 64'(st_tot), 64'd0);
    check("b2b_count", 64'(got_q.size()), 64'd8);
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("b2b_tag", 64'(got_q[i].t), 64'(i));
        check("b2b_out", 64'(got_q[i].d), 64'(100 + i));
        check("b2b_cyc", 64'(got_q[i].c - got_q[0].c), 64'(i));
      end
    end

    // 4. backpressure after the first result
    got_q.delete();
    out_ready = 1'b1;
    send(F_MOVE, W'(32'h10), W'(0), 5'd10, ta, st);
    send(F_MOVE, W'(32'h11), W'(0), 5'd11, ta, st);
    send(F_MOVE, W'(32'h12), W'(0), 5'd12, ta, st);
    out_ready = 1'b0;
    funct = F_MOVE; rs2 = W'(32'h13); rs3 = '0; rd_in = 5'd13; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_out_hold", 64'(out), 64'h11);
      check("bp_tag_hold", 64'(rd_out), 64'd11);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("bp_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("bp_tag", 64'(got_q[i].t), 64'(10 + i));
        check("bp_out", 64'(got_q[i].d), 64'(16 + i));
      end
    end

    // 5. illegal funct, followed by a legal op
    run_one("ill",   F_BAD,  W'(32'h1234), W'(0), 5'd21, W'(0), 1'b1);
    run_one("legal", F_UMAX, W'(3), W'(9), 5'd22, W'(9), 1'b0);

    // 6. asynchronous reset with two ops in flight
    got_q.delete();
    out_ready = 1'b0;
    send(F_MOVE, W'(32'h55), W'(0), 5'd20, ta, st);
    send(F_MOVE, W'(32'h66), W'(0), 5'd23, ta, st);
    check("mid_full", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_outs", 64'({illegal, rd_out, out}), 64'd0);
    check("mid_rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("mid_no_stale", 64'(got_q.size()), 64'd0);
    check("mid_idle", 64'(out_valid), 64'd0);
    run_one("post_rst", F_SMIN, W'(7), all1, 5'd24, all1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t expected finish before 200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/mov_unit_pipe.md
Name: mov_unit_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle move unit in the ALU datapath.
- Executes MOVE, CMOV/min, max and signed min/max on WIDTH-bit operands.
- Two register stages with valid/ready handshake on both sides.
- Carries a destination tag for writeback and flags illegal funct codes.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
TAG_W, 5, destination-register tag width
CLR_ON_STALL, 0, reserved; must be 0 (outputs hold on stall)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  unit accepts operands this cycle
rs1  input  WIDTH  operand 1 (unused by current codes, carried for future modes)
rs2  input  WIDTH  operand 2
rs3  input  WIDTH  operand 3
funct  input  6  operation select
rd_in  input  TAG_W  destination tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
rd_out  output  TAG_W  tag accompanying result
illegal  output  1  result came from an unsupported funct

Behaviour:

Funct codes:
- 110000 MOVE: out = rs2
- 110001 CMOV (unsigned min): out = (rs2 < rs3) ? rs2 : rs3
- 110010 UMAX: out = (rs2 < rs3) ? rs3 : rs2
- 110011 SMIN: signed compare, select as CMOV
- 110100 SMAX: signed compare, select as UMAX
- Any other code: out = 0, illegal = 1

Comparisons and ties:
- Compare is strictly less-than.
- On equality, the min forms return rs3 and the max forms return rs2. Both values are identical, so the result is the same either way.

Stage 1 (S1) register:
- Captures rs2, rs3, rd_in, a decoded op, and a registered lt bit (signed or unsigned per op), plus s1_valid.

Stage 2 (S2) register:
- Captures the selected result, tag, illegal and s2_valid.
- S2 drives out, rd_out, illegal and out_valid directly from registers. There is no combinational path from inputs to outputs.

Handshake:
- s2_take = !s2_valid || out_ready
- s1_take = !s1_valid || (s2_take)
- in_ready = s1_take. Depends only on state and out_ready; never on in_valid.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- S1 to S2 moves when s1_valid && s2_take. s2_valid next = s1_valid when s2_take, else holds.

Latency and throughput:
- Latency is exactly 2 cycles from input transfer to out_valid, with out_ready held high.
- Throughput is 1 result per cycle.

Stall:
- While out_valid && !out_ready, out, rd_out and illegal are held stable.
- With both stages full, in_ready = 0.
- The unit holds at most 2 results. None are dropped or duplicated.

Simultaneous events:
- With S2 full and out_ready = 1, an S1→S2 move and a new input transfer happen in the same cycle.

Reset:
- Asserting rst_n = 0 at any time (including mid-operation) immediately clears s1_valid, s2_valid, out_valid, illegal, out and rd_out to 0.
- All pipeline data registers reset to 0.
- In-flight operations are discarded.
- in_ready is 1 in the first cycle after deassertion.

Width rules:
- Signed compare uses bit WIDTH-1 as the sign bit. There is no extension or truncation; results are exactly WIDTH bits.

Decomposition:
- Shared package mov_pkg holds:
  - funct constants: FN_MOVE, FN_CMOV, FN_UMAX, FN_SMIN, FN_SMAX
  - op_e enum: OP_MOVE, OP_MIN, OP_MAX, OP_ILL
  - sgn flag
- One natural sub-module: mov_cmp_sel, a combinational comparator + selector parametrised by WIDTH and instantiated between S1 and S2.
- The pipeline and handshake stay in mov_unit_pipe.

Test Plan:
1. Reset then MOVE: rst_n low 3 cycles, then rs2=0x0000_00AB, funct=110000, rd_in=7, out_ready=1. Required: out_valid exactly 2 cycles after the transfer, out=0xAB, rd_out=7, illegal=0; all outputs 0 during reset.
2. Signed vs unsigned: rs2=0xFFFF_FFFF, rs3=0x1. Required: CMOV→0x1, UMAX→0xFFFF_FFFF, SMIN→0xFFFF_FFFF, SMAX→0x1. Tie case rs2=rs3=5 → 5 for all four codes.
3. Back-to-back throughput: 8 consecutive ops with in_valid=1 and out_ready=1. Required: in_ready stays 1 and 8 results appear on 8 consecutive cycles in order, tags 0..7.
4. Backpressure: out_ready=0 after the first result while in_valid=1. Required: in_ready drops after 2 ops are held, out is stable; on out_ready=1 the results drain in order with no loss or duplication.
5. Illegal funct: funct=111111 with rs2=0x1234. Required: out=0, illegal=1, rd_out=tag, normal latency; the next legal op has illegal=0.
6. Reset mid-flight: two ops in the pipe, rst_n pulsed low asynchronously between clock edges. Required: out_valid falls immediately without waiting for a clock edge; no stale result appears after release; WIDTH=16 build passes scenarios 1–3.
